// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: start/stop/lap control for the stopwatch datapath.
// Drives the counter enable/clear, freezes split times on the display for
// HOLD_CYC cycles and keeps the latest DEPTH splits in a circular buffer.
module stopwatch_lap_ctrl #(
  parameter int DEPTH    = 4,
  parameter int PTR_W    = 2,
  parameter int HOLD_CYC = 100
) (
  input  logic             i_clk,
  input  logic             i_sclr,
  input  logic             i_key_ss,
  input  logic             i_key_lap,
  input  logic [31:0]      i_digits,
  input  logic             i_rd,
  output logic             o_en,
  output logic             o_clr,
  output logic [31:0]      o_disp,
  output logic             o_frozen,
  output logic [PTR_W:0]   o_lap_cnt,
  output logic             o_ovf,
  output logic [31:0]      o_rd_data,
  output logic             o_rd_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SPLIT, S_STOP} state_t;

  localparam logic [15:0]  HOLD_LD = 16'(HOLD_CYC - 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_t           state, nxt;
  logic [15:0]      hold;
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             lap_ev, capture, flush, pop, full;

  // start/stop beats lap when both arrive together
  assign lap_ev  = i_key_lap & ~i_key_ss;
  assign capture = lap_ev & ((state == S_RUN) | (state == S_SPLIT));
  assign flush   = lap_ev & (state == S_STOP);
  assign full    = (o_lap_cnt == FULL_CNT);
  // a flush empties the buffer, so a pop in that cycle has nothing to return
  assign pop     = i_rd & (o_lap_cnt != '0) & ~flush;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_sclr) state <= S_IDLE;
    else        state <= nxt;
  end

  // next-state decode from key events and hold expiry
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (i_key_ss) nxt = S_RUN;
      S_RUN:   if (i_key_ss) nxt = S_STOP;
               else if (lap_ev) nxt = S_SPLIT;
      S_SPLIT: if (i_key_ss) nxt = S_STOP;
               else if (lap_ev) nxt = S_SPLIT;
               else if (hold == '0) nxt = S_RUN;
      S_STOP:  if (i_key_ss) nxt = S_RUN;
               else if (lap_ev) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // registered counter controls, hold timer and display select
  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      o_en     <= 1'b0;
      o_clr    <= 1'b0;
      o_frozen <= 1'b0;
      o_disp   <= '0;
      hold     <= '0;
    end else begin
      o_en     <= (nxt == S_RUN) | (nxt == S_SPLIT);
      o_clr    <= flush;
      o_frozen <= (nxt == S_SPLIT);
      if (capture)
        hold <= HOLD_LD;
      else if ((state == S_SPLIT) && (hold != '0))
        hold <= hold - 16'd1;
      // o_disp itself acts as the freeze register while splitting
      if (capture)
        o_disp <= i_digits;
      else if (nxt != S_SPLIT)
        o_disp <= i_digits;
    end
  end

  // lap storage; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (capture) mem[wr_ptr] <= i_digits;
  end

  // lap buffer pointers, count, overflow flag and pop port
  always_ff @(posedge i_clk) begin
    if (i_sclr || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_lap_cnt  <= '0;
      o_ovf      <= 1'b0;
      o_rd_valid <= 1'b0;
      if (i_sclr) o_rd_data <= '0;
    end else begin
      o_rd_valid <= pop;
      if (pop) o_rd_data <= mem[rd_ptr];
      case ({capture, pop})
        2'b11: begin
          // pop reads the oldest slot before the push lands, count unchanged
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        2'b10: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (full) begin
            rd_ptr <= rd_ptr + 1'b1;
            o_ovf  <= 1'b1;
          end else begin
            o_lap_cnt <= o_lap_cnt + 1'b1;
          end
        end
        2'b01: begin
          rd_ptr    <= rd_ptr + 1'b1;
          o_lap_cnt <= o_lap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Self-checking bench for stopwatch_lap_ctrl: directed scenarios plus a
// randomized run compared against a behavioural model using a queue.
module tb_stopwatch_lap_ctrl;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int HOLD  = 100;

  logic             clk = 1'b0;
  logic             sclr = 1'b0, key_ss = 1'b0, key_lap = 1'b0, rd = 1'b0;
  logic [31:0]      digits = '0;
  logic             en, clr, frozen, ovf, rd_valid;
  logic [31:0]      disp, rd_data;
  logic [PTR_W:0]   lap_cnt;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit          m_run, m_stop, m_ovf, m_rdv, m_clr;
  int          m_left;
  logic [31:0] m_frz, m_disp, m_rdd;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  stopwatch_lap_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .HOLD_CYC(HOLD)) dut (
    .i_clk(clk), .i_sclr(sclr), .i_key_ss(key_ss), .i_key_lap(key_lap),
    .i_digits(digits), .i_rd(rd), .o_en(en), .o_clr(clr), .o_disp(disp),
    .o_frozen(frozen), .o_lap_cnt(lap_cnt), .o_ovf(ovf),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid)
  );

  task automatic model_step(input bit ss, input bit lap, input bit r,
                            input logic [31:0] d, input bit rst);
    bit eff_lap, fl;
    if (rst) begin
      m_run = 0; m_stop = 0; m_left = 0; m_frz = '0; m_disp = '0;
      q.delete(); m_ovf = 0; m_rdd = '0; m_rdv = 0; m_clr = 0;
    end else begin
      eff_lap = lap && !ss;
      fl      = eff_lap && m_stop;
      m_clr   = fl;
      m_rdv   = 0;
      if (r && !fl && q.size() > 0) begin
        m_rdd = q.pop_front();
        m_rdv = 1;
      end
      if (ss) begin
        m_left = 0;
        if (m_run) begin m_run = 0; m_stop = 1; end
        else       begin m_run = 1; m_stop = 0; end
      end else if (eff_lap && m_run) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          m_ovf = 1;
        end
        q.push_back(d);
        m_left = HOLD;
        m_frz  = d;
      end else if (fl) begin
        m_stop = 0;
        q.delete();
        m_ovf = 0;
      end else if (m_left > 0) begin
        m_left--;
      end
      m_disp = (m_left > 0) ? m_frz : d;
    end
  endtask

  // drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic tick(input logic ss, input logic lap, input logic r,
                      input logic [31:0] d, input logic rst);
    key_ss = ss; key_lap = lap; rd = r; digits = d; sclr = rst;
    @(posedge clk);
    model_step(ss, lap, r, d, rst);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, 1, 32'hdead_beef, 1);
    tick(0, 0, 0, 32'h0, 1);
    checks++; if (en !== 1'b0)       begin errors++; $display("FAIL reset_en got=%b exp=0", en); end
    checks++; if (clr !== 1'b0)      begin errors++; $display("FAIL reset_clr got=%b exp=0", clr); end
    checks++; if (disp !== 32'h0)    begin errors++; $display("FAIL reset_disp got=%h exp=0", disp); end
    checks++; if (frozen !== 1'b0)   begin errors++; $display("FAIL reset_frozen got=%b exp=0", frozen); end
    checks++; if (lap_cnt !== '0)    begin errors++; $display("FAIL reset_cnt got=%0d exp=0", lap_cnt); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
  endtask

  task automatic test_start_stop_clear();
    int bad;
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 32'h0, 0);
    tick(0, 1, 0, 32'h0, 0);  // lap in IDLE is ignored
    checks++; if (en !== 1'b0 || lap_cnt !== '0) begin errors++; $display("FAIL idle_lap en=%b cnt=%0d exp en=0 cnt=0", en, lap_cnt); end
    tick(1, 0, 0, 32'h0, 0);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL start_en got=%b exp=1", en); end
    bad = 0;
    for (int i = 0; i < 189; i++) begin
      tick(0, 0, 0, 32'(i), 0);
      if (en !== 1'b1 || disp !== 32'(i)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL run_hold got=%0d bad cycles exp=0", bad); end
    tick(1, 0, 0, 32'h55, 0);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL stop_en got=%b exp=0", en); end
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 32'h55, 0);
    tick(0, 1, 0, 32'h55, 0);
    checks++; if (clr !== 1'b1 || en !== 1'b0) begin errors++; $display("FAIL clr_pulse clr=%b en=%b exp clr=1 en=0", clr, en); end
    tick(0, 0, 0, 32'h0, 0);
    checks++; if (clr !== 1'b0 || disp !== 32'h0) begin errors++; $display("FAIL clr_end clr=%b disp=%h exp clr=0 disp=0", clr, disp); end
    tick(1, 0, 0, 32'h0, 0);  // back in IDLE: ss must start again
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL restart_en got=%b exp=1", en); end
  endtask

  task automatic test_split_hold();
    int nfrz, bad;
    logic [31:0] d;
    tick(0, 0, 0, 32'h0, 1);
    tick(1, 0, 0, 32'h0, 0);
    tick(0, 1, 0, 32'h0000_1234, 0);
    nfrz = 0; bad = 0; d = '0;
    for (int i = 0; i < 120; i++) begin
      if (frozen === 1'b1) begin
        nfrz++;
        if (disp !== 32'h0000_1234) bad++;
      end
      if (en !== 1'b1) bad++;
      d = $urandom;
      tick(0, 0, 0, d, 0);
    end
    checks++; if (nfrz != HOLD) begin errors++; $display("FAIL split_len got=%0d exp=%0d", nfrz, HOLD); end
    checks++; if (bad != 0) begin errors++; $display("FAIL split_disp got=%0d bad cycles exp=0", bad); end
    checks++; if (frozen !== 1'b0 || disp !== d) begin errors++; $display("FAIL split_live frozen=%b disp=%h exp 0 %h", frozen, disp, d); end
    checks++; if (lap_cnt !== 3'd1) begin errors++; $display("FAIL split_cnt got=%0d exp=1", lap_cnt); end
  endtask

  task automatic test_overflow();
    tick(0, 0, 0, 32'h0, 1);
    tick(1, 0, 0, 32'h0, 0);
    for (int v = 1; v <= 5; v++) tick(0, 1, 0, 32'(v), 0);
    checks++; if (lap_cnt !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_state cnt=%0d ovf=%b exp 4 1", lap_cnt, ovf); end
    for (int v = 2; v <= 5; v++) begin
      tick(0, 0, 1, 32'h0, 0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'(v)) begin errors++; $display("FAIL ovf_pop valid=%b data=%h exp 1 %h", rd_valid, rd_data, v); end
    end
    tick(0, 0, 1, 32'h0, 0);
    checks++; if (rd_valid !== 1'b0 || lap_cnt !== '0) begin errors++; $display("FAIL empty_pop valid=%b cnt=%0d exp 0 0", rd_valid, lap_cnt); end
  endtask

  task automatic test_back_to_back();
    tick(0, 0, 0, 32'h0, 1);
    tick(1, 0, 0, 32'h0, 0);
    for (int v = 10; v <= 13; v++) tick(0, 1, 0, 32'(v), 0);
    tick(0, 1, 1, 32'd14, 0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd10) begin errors++; $display("FAIL pushpop_data valid=%b data=%h exp 1 a", rd_valid, rd_data); end
    checks++; if (lap_cnt !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL pushpop_cnt cnt=%0d ovf=%b exp 4 0", lap_cnt, ovf); end
    for (int v = 11; v <= 14; v++) begin
      tick(0, 0, 1, 32'h0, 0);
      checks++; if (rd_data !== 32'(v)) begin errors++; $display("FAIL pushpop_drain got=%h exp=%h", rd_data, v); end
    end
  endtask

  task automatic test_ss_lap_together();
    tick(0, 0, 0, 32'h0, 1);
    tick(1, 0, 0, 32'h0, 0);
    tick(1, 1, 0, 32'h99, 0);
    checks++; if (en !== 1'b0 || frozen !== 1'b0 || lap_cnt !== '0) begin errors++; $display("FAIL both_run en=%b frozen=%b cnt=%0d exp 0 0 0", en, frozen, lap_cnt); end
    tick(1, 1, 0, 32'h99, 0);
    checks++; if (en !== 1'b1 || clr !== 1'b0) begin errors++; $display("FAIL both_stop en=%b clr=%b exp 1 0", en, clr); end
  endtask

  task automatic test_sclr_split();
    tick(0, 0, 0, 32'h0, 1);
    tick(1, 0, 0, 32'h0, 0);
    for (int v = 1; v <= 3; v++) tick(0, 1, 0, 32'(v + 7), 0);
    tick(0, 1, 1, 32'h77, 1);
    checks++; if ({en, clr, frozen, ovf, rd_valid} !== 5'b0 || disp !== '0 || lap_cnt !== '0 || rd_data !== '0) begin
      errors++; $display("FAIL sclr_split en=%b clr=%b frz=%b ovf=%b v=%b disp=%h cnt=%0d rdd=%h exp all 0", en, clr, frozen, ovf, rd_valid, disp, lap_cnt, rd_data);
    end
    tick(0, 0, 1, 32'h0, 0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL sclr_pop got=%b exp=0", rd_valid); end
  endtask

  task automatic test_random();
    bit ss, lap, r, rst;
    tick(0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 3000; i++) begin
      ss  = ($urandom_range(99) < 3);
      lap = ($urandom_range(99) < 8);
      r   = ($urandom_range(99) < 15);
      rst = ($urandom_range(999) < 3);
      if (m_stop && lap && !ss) r = 0;
      tick(ss, lap, r, $urandom, rst);
      checks++; if (en !== m_run)        begin errors++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", i, en, m_run); end
      checks++; if (clr !== m_clr)       begin errors++; $display("FAIL rnd_clr cyc=%0d got=%b exp=%b", i, clr, m_clr); end
      checks++; if (frozen !== (m_left > 0)) begin errors++; $display("FAIL rnd_frozen cyc=%0d got=%b exp=%b", i, frozen, m_left > 0); end
      checks++; if (disp !== m_disp)     begin errors++; $display("FAIL rnd_disp cyc=%0d got=%h exp=%h", i, disp, m_disp); end
      checks++; if (lap_cnt !== (PTR_W+1)'(q.size())) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, lap_cnt, q.size()); end
      checks++; if (ovf !== m_ovf)       begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, ovf, m_ovf); end
      checks++; if (rd_valid !== m_rdv)  begin errors++; $display("FAIL rnd_rdv cyc=%0d got=%b exp=%b", i, rd_valid, m_rdv); end
      checks++; if (rd_data !== m_rdd)   begin errors++; $display("FAIL rnd_rdd cyc=%0d got=%h exp=%h", i, rd_data, m_rdd); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_start_stop_clear();
    test_split_hold();
    test_overflow();
    test_back_to_back();
    test_ss_lap_together();
    test_sclr_split();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
